// File: rtl/cv_rend_pkg.sv
// Shared types and constants for the render-order sequencer.
// Slot entries are {en, 3'bx, id[3:0]}; the walk covers NUM_SLOTS slots per frame.
package cv_rend_pkg;

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned EN_BIT    = 7;
    localparam int unsigned ID_MSB    = 3;
    localparam int unsigned ID_W      = ID_MSB + 1;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned WD_W      = 20;

    localparam logic [ID_W-1:0] SPRITE_ID_DEF = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CHECK = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic is_last_slot(input logic [SLOT_W-1:0] slot);
        return slot == SLOT_W'(NUM_SLOTS - 1);
    endfunction

endpackage

// File: rtl/cv_rend_wdog.sv
// WAIT-state watchdog: counts enabled cycles after a clear and flags the
// TIMEOUT-th enabled cycle combinationally so the FSM can abandon that same cycle.
module cv_rend_wdog
    import cv_rend_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT = 20'd1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire_c
);

    logic [WD_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire_c) begin
            r_cnt <= WD_W'(r_cnt + WD_W'(1));
        end
    end

    assign o_expire_c = i_en && (r_cnt == WD_W'(TIMEOUT - WD_W'(1)));

endmodule

// File: rtl/cv_rend_seq.sv
// Render-order sequencer: on a kick walks the eight slots, issues one
// start/done transaction per enabled slot, then signals frame end and irq.
module cv_rend_seq
    import cv_rend_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT   = 20'd1_000_000,
    parameter logic [ID_W-1:0] SPRITE_ID = SPRITE_ID_DEF
) (
    input  logic              ps_c_clk,
    input  logic              reset,
    input  logic [1:0]        r_virq,
    input  logic [7:0]        r_rend_order,
    input  logic [CNT_W-1:0]  r_sp_count,
    output logic [SLOT_W-1:0] rend_order_sel,
    output logic              l_start,
    output logic [ID_W-1:0]   l_id,
    output logic [CNT_W-1:0]  l_count,
    input  logic              l_done,
    output logic              frame_done,
    output logic              irq,
    output logic              busy,
    output logic              st_overrun,
    output logic              st_timeout,
    output logic [CNT_W-1:0]  frame_cnt
);

    state_t            r_state;
    logic [SLOT_W-1:0] r_slot;
    logic              r_en;
    logic [ID_W-1:0]   r_id;
    logic              r_pend;

    logic w_kick_ok;
    logic w_pend_nxt;
    logic w_wd_clr;
    logic w_wd_en;
    logic w_wd_expire;
    logic w_advance;
    logic w_unused_entry;

    // Entry bits 6:4 carry no meaning for the sequencer.
    assign w_unused_entry = ^r_rend_order[6:4];

    assign rend_order_sel = r_slot;

    assign w_kick_ok  = (r_state == ST_IDLE) && r_virq[1];
    assign w_pend_nxt = w_kick_ok ? 1'b0
                      : ((r_state == ST_DONE) && r_virq[0]) ? 1'b1
                      : r_pend;

    assign w_wd_clr = (r_state == ST_ISSUE);
    assign w_wd_en  = (r_state == ST_WAIT);

    // A done in the expiry cycle is a normal completion; both paths advance.
    assign w_advance = ((r_state == ST_CHECK) && !r_en)
                    || ((r_state == ST_WAIT) && (l_done || w_wd_expire));

    cv_rend_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_clk      (ps_c_clk),
        .i_rst      (reset),
        .i_clr      (w_wd_clr),
        .i_en       (w_wd_en),
        .o_expire_c (w_wd_expire)
    );

    always_ff @(posedge ps_c_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_slot     <= '0;
            r_en       <= 1'b0;
            r_id       <= '0;
            r_pend     <= 1'b0;
            l_start    <= 1'b0;
            l_id       <= '0;
            l_count    <= '0;
            frame_done <= 1'b0;
            irq        <= 1'b0;
            busy       <= 1'b0;
            st_overrun <= 1'b0;
            st_timeout <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            l_start    <= 1'b0;
            frame_done <= 1'b0;
            r_pend     <= w_pend_nxt;
            irq        <= w_pend_nxt & r_virq[0];

            if (r_virq[1] && (r_state != ST_IDLE)) begin
                st_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_virq[1]) begin
                        r_state    <= ST_FETCH;
                        r_slot     <= '0;
                        st_overrun <= 1'b0;
                        st_timeout <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_en    <= r_rend_order[EN_BIT];
                    r_id    <= r_rend_order[ID_MSB:0];
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (r_en) begin
                        r_state <= ST_ISSUE;
                        l_start <= 1'b1;
                        l_id    <= r_id;
                        l_count <= (r_id == SPRITE_ID) ? r_sp_count : '0;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!l_done && w_wd_expire) begin
                        st_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Shared slot advance for skipped, completed and abandoned slots.
            if (w_advance) begin
                if (is_last_slot(r_slot)) begin
                    r_state    <= ST_DONE;
                    frame_done <= 1'b1;
                    frame_cnt  <= CNT_W'(frame_cnt + CNT_W'(1));
                end else begin
                    r_slot  <= SLOT_W'(r_slot + SLOT_W'(1));
                    r_state <= ST_FETCH;
                end
            end
        end
    end

endmodule
